// File: rtl/bus_master_port_if.sv
// Bit-serial system bus signals between a master port and the arbiter/slave side.
interface bus_master_port_if;
  logic bus_request;
  logic bus_grant;
  logic slave_ack;
  logic m_dout;
  logic m_valid;
  logic s_din;
  logic s_valid;

  modport master (
    output bus_request, m_dout, m_valid,
    input  bus_grant, slave_ack, s_din, s_valid
  );

  modport slave (
    input  bus_request, m_dout, m_valid,
    output bus_grant, slave_ack, s_din, s_valid
  );
endinterface

// File: rtl/bus_master_port.sv
// Bus master port: turns one read/write command into a bit-serial burst on the
// system bus (arbitration, serial header, per-beat acknowledged data transfer).
//
// state      | meaning
// -----------+-------------------------------------------------------------
// S_IDLE     | waiting for a read/write strobe rising edge
// S_REQUEST  | bus_request high, waiting for bus_grant (timed)
// S_SEND_HDR | shifting out slave id, rw bit and address, LSB first
// S_WAIT_ACK | waiting for slave_ack before the next beat (timed)
// S_WRITE_BEAT | shifting out one write beat, LSB first
// S_READ_BEAT  | shifting in one read beat on s_valid cycles
// S_DONE     | one-cycle done pulse
// S_ABORT    | one-cycle abort, error set
module bus_master_port #(
  parameter int SLAVE_LEN = 2,
  parameter int ADDR_LEN  = 12,
  parameter int DATA_LEN  = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 read,
  input  logic                 write,
  input  logic [DATA_LEN-1:0]  data_in,
  input  logic [ADDR_LEN:0]    address,
  input  logic [SLAVE_LEN-1:0] slave_select,
  input  logic [ADDR_LEN:0]    burst_num,
  bus_master_port_if.master    bus,
  output logic [DATA_LEN-1:0]  rx_data,
  output logic                 rx_valid,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  localparam int HDR_LEN = SLAVE_LEN + 1 + ADDR_LEN;
  localparam int SRW     = (HDR_LEN > DATA_LEN) ? HDR_LEN : DATA_LEN;
  localparam int CW      = $clog2(SRW);
  localparam int TW      = $clog2(TIMEOUT + 1);
  localparam int BW      = ADDR_LEN + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_REQUEST, S_SEND_HDR, S_WAIT_ACK,
    S_WRITE_BEAT, S_READ_BEAT, S_DONE, S_ABORT
  } state_t;

  state_t               state;
  logic                 read_q, write_q;
  logic [SLAVE_LEN-1:0] slave_q;
  logic [ADDR_LEN-1:0]  addr_q;
  logic [DATA_LEN-1:0]  data_q;
  logic                 rw_q;
  logic [BW-1:0]        beats_q;
  logic [BW-1:0]        beat_cnt;
  logic [TW-1:0]        tmr;
  logic [CW-1:0]        cnt;
  logic [SRW-1:0]       sr;
  logic [DATA_LEN-1:0]  rx_sr;

  logic                 start_rd, start_wr;
  logic [BW-1:0]        beat_nxt;
  logic [DATA_LEN-1:0]  beat_data;
  logic [DATA_LEN-1:0]  rx_word;
  logic [HDR_LEN-1:0]   hdr_word;
  logic                 last_beat;
  logic                 grant_lost;
  logic                 timeout_hit;
  logic                 beat_end;
  logic                 unused_addr_msb;

  assign unused_addr_msb = address[ADDR_LEN];
  assign start_rd  = read & ~read_q;
  assign start_wr  = write & ~write_q;
  assign beat_nxt  = beat_cnt + 1'b1;
  assign beat_data = data_q + DATA_LEN'(beat_cnt);
  assign rx_word   = {bus.s_din, rx_sr[DATA_LEN-1:1]};
  assign hdr_word  = {addr_q, rw_q, slave_q};
  assign last_beat = (beat_nxt == beats_q);

  // Once granted, the grant must hold until the last beat has left.
  assign grant_lost = !bus.bus_grant &&
                      (state == S_SEND_HDR || state == S_WAIT_ACK ||
                       state == S_WRITE_BEAT || state == S_READ_BEAT);
  assign timeout_hit = (tmr == '0) &&
                       ((state == S_REQUEST && !bus.bus_grant) ||
                        (state == S_WAIT_ACK && !bus.slave_ack));
  assign beat_end = (cnt == '0) &&
                    ((state == S_WRITE_BEAT) ||
                     (state == S_READ_BEAT && bus.s_valid));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= S_IDLE;
      read_q          <= 1'b0;
      write_q         <= 1'b0;
      slave_q         <= '0;
      addr_q          <= '0;
      data_q          <= '0;
      rw_q            <= 1'b0;
      beats_q         <= '0;
      beat_cnt        <= '0;
      tmr             <= '0;
      cnt             <= '0;
      sr              <= '0;
      rx_sr           <= '0;
      rx_data         <= '0;
      rx_valid        <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      error           <= 1'b0;
      bus.bus_request <= 1'b0;
      bus.m_dout      <= 1'b0;
      bus.m_valid     <= 1'b0;
    end else begin
      read_q   <= read;
      write_q  <= write;
      rx_valid <= 1'b0;
      done     <= 1'b0;

      if (grant_lost || timeout_hit) begin
        state           <= S_ABORT;
        bus.bus_request <= 1'b0;
        bus.m_valid     <= 1'b0;
        bus.m_dout      <= 1'b0;
        error           <= 1'b1;
      end else if (beat_end) begin
        if (state == S_READ_BEAT) begin
          rx_sr    <= rx_word;
          rx_data  <= rx_word;
          rx_valid <= 1'b1;
        end
        beat_cnt    <= beat_nxt;
        bus.m_valid <= 1'b0;
        bus.m_dout  <= 1'b0;
        if (last_beat) begin
          state           <= S_DONE;
          done            <= 1'b1;
          bus.bus_request <= 1'b0;
        end else begin
          state <= S_WAIT_ACK;
          tmr   <= TW'(TIMEOUT - 1);
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (start_rd || start_wr) begin
              slave_q         <= slave_select;
              addr_q          <= address[ADDR_LEN-1:0];
              data_q          <= data_in;
              rw_q            <= start_rd;
              beats_q         <= (burst_num == '0) ? BW'(1) : burst_num;
              beat_cnt        <= '0;
              error           <= 1'b0;
              busy            <= 1'b1;
              bus.bus_request <= 1'b1;
              tmr             <= TW'(TIMEOUT - 1);
              state           <= S_REQUEST;
            end
          end
          S_REQUEST: begin
            if (bus.bus_grant) begin
              state       <= S_SEND_HDR;
              bus.m_valid <= 1'b1;
              bus.m_dout  <= hdr_word[0];
              sr          <= SRW'(hdr_word >> 1);
              cnt         <= CW'(HDR_LEN - 1);
            end else begin
              tmr <= tmr - 1'b1;
            end
          end
          S_SEND_HDR: begin
            if (cnt == '0) begin
              state       <= S_WAIT_ACK;
              bus.m_valid <= 1'b0;
              bus.m_dout  <= 1'b0;
              tmr         <= TW'(TIMEOUT - 1);
            end else begin
              bus.m_dout <= sr[0];
              sr         <= sr >> 1;
              cnt        <= cnt - 1'b1;
            end
          end
          S_WAIT_ACK: begin
            if (bus.slave_ack) begin
              cnt <= CW'(DATA_LEN - 1);
              if (rw_q) begin
                state <= S_READ_BEAT;
              end else begin
                state       <= S_WRITE_BEAT;
                bus.m_valid <= 1'b1;
                bus.m_dout  <= beat_data[0];
                sr          <= SRW'(beat_data >> 1);
              end
            end else begin
              tmr <= tmr - 1'b1;
            end
          end
          S_WRITE_BEAT: begin
            bus.m_dout <= sr[0];
            sr         <= sr >> 1;
            cnt        <= cnt - 1'b1;
          end
          S_READ_BEAT: begin
            if (bus.s_valid) begin
              rx_sr <= rx_word;
              cnt   <= cnt - 1'b1;
            end
          end
          S_DONE: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          S_ABORT: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bus_master_port.sv
// Scoreboard bench for bus_master_port: expected header/write/read beats are
// queued at command time and consumed as the port produces them.
module tb_bus_master_port;
  logic        clk = 1'b0;
  logic        reset;
  logic        read, write;
  logic [7:0]  data_in;
  logic [12:0] address;
  logic [1:0]  slave_select;
  logic [12:0] burst_num;
  logic [7:0]  rx_data;
  logic        rx_valid, busy, done, error;
  logic        grant_en;

  always #5 clk = ~clk;

  bus_master_port_if bif();
  assign bif.bus_grant = grant_en & bif.bus_request;

  bus_master_port dut (
    .clk(clk), .reset(reset), .read(read), .write(write),
    .data_in(data_in), .address(address), .slave_select(slave_select),
    .burst_num(burst_num), .bus(bif), .rx_data(rx_data),
    .rx_valid(rx_valid), .busy(busy), .done(done), .error(error)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int req_cycles, done_pulses, busy_rises, bit_cnt;
  logic        prev_busy = 1'b0;
  logic [14:0] hdr_sr;
  logic [7:0]  byte_sr;
  logic [14:0] exp_hdr[$];
  logic [7:0]  exp_wr[$];
  logic [7:0]  exp_rx[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] hdr_of(input logic [1:0] s, input logic rw, input logic [12:0] a);
    return {a[11:0], rw, s};
  endfunction

  // Output monitor: collects serial bits and read beats, checks against queues.
  initial begin
    req_cycles = 0; done_pulses = 0; busy_rises = 0; bit_cnt = 0;
    hdr_sr = '0; byte_sr = '0;
    forever begin
      @(negedge clk);
      if (bif.bus_request) req_cycles++;
      if (done) done_pulses++;
      if (busy && !prev_busy) busy_rises++;
      prev_busy = busy;
      if (!busy) begin
        bit_cnt = 0;
      end else if (bif.m_valid) begin
        bit_cnt++;
        if (bit_cnt <= 15) begin
          hdr_sr = {bif.m_dout, hdr_sr[14:1]};
          if (bit_cnt == 15) begin
            if (exp_hdr.size() == 0) check("hdr_unexpected", 32'd1, 32'd0);
            else check("hdr", 32'(hdr_sr), 32'(exp_hdr.pop_front()));
          end
        end else begin
          byte_sr = {bif.m_dout, byte_sr[7:1]};
          if ((bit_cnt - 15) % 8 == 0) begin
            if (exp_wr.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
            else check("wr_beat", 32'(byte_sr), 32'(exp_wr.pop_front()));
          end
        end
      end
      if (rx_valid) begin
        if (exp_rx.size() == 0) check("rx_unexpected", 32'd1, 32'd0);
        else check("rx_beat", 32'(rx_data), 32'(exp_rx.pop_front()));
      end
    end
  end

  task automatic start_cmd(input logic rd, input logic wr, input logic [1:0] s,
                           input logic [12:0] a, input logic [7:0] d, input logic [12:0] b);
    @(negedge clk);
    req_cycles = 0; done_pulses = 0; busy_rises = 0;
    slave_select = s; address = a; data_in = d; burst_num = b;
    read = rd; write = wr;
    @(negedge clk);
    read = 1'b0; write = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_bits(input int n, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (bit_cnt >= n) break;
      @(negedge clk);
    end
    check("bits_reached", 32'(bit_cnt >= n), 32'd1);
  endtask

  // Slave model for reads: ack each beat, then feed bits LSB first with s_valid
  // gaps during which s_din carries the wrong value.
  task automatic serve_read(input logic [15:0] bytes, input int n);
    logic       pm;
    logic [7:0] b;
    int         t;
    pm = 1'b0;
    t = 0;
    while (!(pm && !bif.m_valid)) begin
      pm = bif.m_valid;
      @(negedge clk);
      t++;
      if (t > 200) begin
        check("rd_hdr_timeout", 32'd1, 32'd0);
        return;
      end
    end
    for (int k = 0; k < n; k++) begin
      b = (k == 0) ? bytes[7:0] : bytes[15:8];
      bif.slave_ack = 1'b1;
      @(negedge clk);
      bif.slave_ack = 1'b0;
      for (int i = 0; i < 8; i++) begin
        if (i == 2 || i == 5) begin
          bif.s_valid = 1'b0;
          bif.s_din   = ~b[i];
          repeat (2) @(negedge clk);
        end
        bif.s_valid = 1'b1;
        bif.s_din   = b[i];
        @(negedge clk);
      end
      bif.s_valid = 1'b0;
      bif.s_din   = 1'b0;
    end
  endtask

  function automatic logic [14:0] outs();
    return {bif.bus_request, bif.m_valid, bif.m_dout, rx_valid, busy, done, error, rx_data};
  endfunction

  initial begin
    reset = 1'b0; read = 1'b0; write = 1'b0;
    data_in = '0; address = '0; slave_select = '0; burst_num = '0;
    grant_en = 1'b1;
    bif.slave_ack = 1'b0; bif.s_din = 1'b0; bif.s_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", 32'(outs()), 32'd0);
    reset = 1'b1;

    // reset in the middle of a burst, then a fresh write
    bif.slave_ack = 1'b1;
    exp_hdr.push_back(hdr_of(2'd1, 1'b0, 13'h00F));
    start_cmd(1'b0, 1'b1, 2'd1, 13'h00F, 8'hAA, 13'd3);
    wait_bits(19, 100);
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_outputs", 32'(outs()), 32'd0);
    check("rst_mid_request", 32'(bif.bus_request), 32'd0);
    @(negedge clk);
    check("rst_mid_outputs2", 32'(outs()), 32'd0);
    reset = 1'b1;
    exp_hdr.push_back(hdr_of(2'd3, 1'b0, 13'h0FFF));
    exp_wr.push_back(8'h5A);
    start_cmd(1'b0, 1'b1, 2'd3, 13'h0FFF, 8'h5A, 13'd1);
    wait_idle("post_rst", 200);
    check("post_rst_done", 32'(done_pulses), 32'd1);

    // write burst of three with immediate grant and ack
    exp_hdr.push_back(hdr_of(2'd2, 1'b0, 13'h0A5));
    exp_wr.push_back(8'h10); exp_wr.push_back(8'h11); exp_wr.push_back(8'h12);
    start_cmd(1'b0, 1'b1, 2'd2, 13'h0A5, 8'h10, 13'd3);
    wait_idle("wr3", 200);
    check("wr3_req_cycles", 32'(req_cycles), 32'd43);
    check("wr3_done", 32'(done_pulses), 32'd1);
    check("wr3_error", 32'(error), 32'd0);

    // read burst of two with s_valid gaps
    bif.slave_ack = 1'b0;
    exp_hdr.push_back(hdr_of(2'd1, 1'b1, 13'h123));
    exp_rx.push_back(8'h3C); exp_rx.push_back(8'hC3);
    start_cmd(1'b1, 1'b0, 2'd1, 13'h123, 8'h00, 13'd2);
    serve_read(16'hC33C, 2);
    wait_idle("rd2", 200);
    check("rd2_done", 32'(done_pulses), 32'd1);
    check("rd2_rx_data", 32'(rx_data), 32'h0C3);

    // burst_num 0 is one beat; a write edge while busy is dropped
    bif.slave_ack = 1'b1;
    exp_hdr.push_back(hdr_of(2'd0, 1'b0, 13'h055));
    exp_wr.push_back(8'hFF);
    start_cmd(1'b0, 1'b1, 2'd0, 13'h055, 8'hFF, 13'd0);
    repeat (5) @(negedge clk);
    write = 1'b1;
    @(negedge clk);
    write = 1'b0;
    wait_idle("b0", 200);
    check("b0_req_cycles", 32'(req_cycles), 32'd25);
    check("b0_done", 32'(done_pulses), 32'd1);
    repeat (20) @(negedge clk);
    check("b0_no_queued", 32'(busy_rises), 32'd1);

    // simultaneous read and write edges: read wins, address MSB dropped
    bif.slave_ack = 1'b0;
    exp_hdr.push_back(hdr_of(2'd0, 1'b1, 13'h1ABC));
    exp_rx.push_back(8'h96);
    start_cmd(1'b1, 1'b1, 2'd0, 13'h1ABC, 8'h33, 13'd1);
    serve_read(16'h0096, 1);
    wait_idle("rw_both", 200);
    check("rw_both_done", 32'(done_pulses), 32'd1);

    // grant never arrives
    grant_en = 1'b0;
    bif.slave_ack = 1'b1;
    start_cmd(1'b0, 1'b1, 2'd2, 13'h005, 8'h77, 13'd1);
    wait_idle("no_grant", 400);
    check("no_grant_error", 32'(error), 32'd1);
    check("no_grant_done", 32'(done_pulses), 32'd0);
    check("no_grant_req_cycles", 32'(req_cycles), 32'd255);
    check("no_grant_request", 32'(bif.bus_request), 32'd0);
    grant_en = 1'b1;

    // grant withdrawn during the second beat
    exp_hdr.push_back(hdr_of(2'd2, 1'b0, 13'h0A5));
    exp_wr.push_back(8'h20);
    start_cmd(1'b0, 1'b1, 2'd2, 13'h0A5, 8'h20, 13'd3);
    wait_bits(26, 100);
    grant_en = 1'b0;
    wait_idle("grant_loss", 50);
    grant_en = 1'b1;
    check("grant_loss_error", 32'(error), 32'd1);
    check("grant_loss_done", 32'(done_pulses), 32'd0);
    check("grant_loss_request", 32'(bif.bus_request), 32'd0);

    // beat data wraps modulo 256; error clears on new start
    exp_hdr.push_back(hdr_of(2'd3, 1'b0, 13'h7FF));
    exp_wr.push_back(8'hFE); exp_wr.push_back(8'hFF); exp_wr.push_back(8'h00);
    start_cmd(1'b0, 1'b1, 2'd3, 13'h7FF, 8'hFE, 13'd3);
    wait_idle("wrap", 200);
    check("wrap_done", 32'(done_pulses), 32'd1);
    check("wrap_error", 32'(error), 32'd0);

    repeat (3) @(negedge clk);
    check("queues_drained", 32'(exp_hdr.size() + exp_wr.size() + exp_rx.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/bus_master_port.md
Name: bus_master_port

Overview:
- Bus-side master port that executes one command from the command processor as a bit-serial burst transaction on the system bus.
- One instance is used per master.
- It edge-detects the read/write strobes and captures the command fields. It then requests the bus from the arbiter, shifts out a serial header, and transfers burst_num data beats with per-beat slave acknowledge.
- Read data is returned on a parallel output for display.

Parameters:
- SLAVE_LEN, 2, width of slave id
- ADDR_LEN, 12, slave-local address width
- DATA_LEN, 8, data beat width
- TIMEOUT, 255, max cycles waiting for bus_grant or slave_ack before abort

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- read  in  1  read strobe, level; rising edge starts a read
- write  in  1  write strobe, level; rising edge starts a write
- data_in  in  DATA_LEN  write seed data
- address  in  ADDR_LEN+1  start address; MSB ignored
- slave_select  in  SLAVE_LEN  target slave id
- burst_num  in  ADDR_LEN+1  beat count
- bus_grant  in  1  arbiter grant
- slave_ack  in  1  slave ready for next beat
- s_din  in  1  serial read data from slave
- s_valid  in  1  s_din qualifier
- bus_request  out  1  request to arbiter
- m_dout  out  1  serial header/write data to slave
- m_valid  out  1  m_dout qualifier
- rx_data  out  DATA_LEN  last completed read beat
- rx_valid  out  1  one-cycle pulse per read beat
- busy  out  1  transaction in progress
- done  out  1  one-cycle pulse on normal completion
- error  out  1  sticky abort flag

Behaviour:
- Reset (reset==0 at clk edge):
  - state=IDLE
  - all outputs 0, rx_data=0, error=0
  - edge-detect registers=0
- Edge detect: registered previous read/write values; start = input high AND previous low.
  - read and write rising on the same cycle: read wins.
  - Edges while busy=1 are ignored and not queued.
- IDLE:
  - On start: latch slave_select, address[ADDR_LEN-1:0], data_in, rw (1=read).
  - Latch beats = burst_num; burst_num==0 is treated as 1.
  - Clear error. Go to REQUEST with busy=1 from the next cycle.
- REQUEST:
  - bus_request=1.
  - bus_grant sampled high -> SEND_HDR on the next cycle.
  - After TIMEOUT cycles without grant -> ABORT.
- SEND_HDR:
  - HDR_LEN = SLAVE_LEN+1+ADDR_LEN cycles (15 at defaults).
  - m_valid=1, one bit per cycle, in order: slave id LSB first, then rw bit, then address LSB first.
  - Then go to WAIT_ACK.
- WAIT_ACK:
  - m_valid=0.
  - slave_ack high -> WRITE_BEAT or READ_BEAT per rw.
  - TIMEOUT cycles without ack -> ABORT.
- WRITE_BEAT:
  - DATA_LEN cycles, m_valid=1, LSB first.
  - Beat k (0-based) carries (data_in + k) mod 2^DATA_LEN.
- READ_BEAT:
  - Shift in s_din only on cycles with s_valid=1, LSB first; stall indefinitely otherwise.
  - After DATA_LEN valid bits: rx_data updates and rx_valid pulses in the same cycle.
- End of beat:
  - Beat counter (ADDR_LEN+1 bits) increments.
  - If counter==beats -> DONE, else -> WAIT_ACK.
- DONE:
  - One cycle: done=1, bus_request=0, busy=0 on the next cycle, return to IDLE.
- ABORT:
  - One cycle: bus_request=0, m_valid=0, error=1 (sticky until next start), return to IDLE.
  - Does not pulse done.
- Grant loss: bus_grant low in any state after REQUEST -> ABORT.
- bus_request stays high continuously from REQUEST through the final beat.
- Reset mid-transaction: immediate return to reset values on that edge; bus_request drops.
- Maximum burst 4095 beats; the counter must not overflow at 4095.

Test Plan:
- Reset for 2 cycles mid-burst -> all outputs 0 the next cycle; bus_request=0; new write edge accepted afterwards.
- Write, slave=2, addr=0x0A5, data=0x10, burst=3, immediate grant/ack:
  - 15 header bits 0,1,0,1,0,1,0,0,1,0,1,0,0,0,0.
  - Data bytes 0x10, 0x11, 0x12 LSB first.
  - done pulse; total bus_request high time = 1+15+3×(1+8) cycles.
- Read, slave=1, burst=2:
  - Slave returns 0x3C then 0xC3 with s_valid gaps.
  - rx_valid pulses twice, rx_data=0x3C then 0xC3.
  - No bit is sampled while s_valid=0.
- burst_num=0 write of 0xFF -> exactly one beat sent; write edge during busy ignored; read and write edges on the same cycle -> read executed.
- Grant held low 255 cycles -> error=1, no done, bus_request drops. Grant removed during beat 2 -> ABORT, error=1.
- Data wrap: data=0xFE, burst=3 -> beats 0xFE, 0xFF, 0x00.
